// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } state_e;

    localparam logic [3:0] OPC_RTYPE = 4'h0;
    localparam logic [3:0] OPC_ADDI  = 4'h1;
    localparam logic [3:0] OPC_LW    = 4'h8;
    localparam logic [3:0] OPC_SW    = 4'h9;
    localparam logic [3:0] OPC_BEQ   = 4'hA;
    localparam logic [3:0] OPC_JMP   = 4'hC;
    localparam logic [3:0] OPC_HALT  = 4'hF;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;

    localparam logic [1:0] PC_SRC_PLUS1  = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_REG = 2'd0;
    localparam logic [1:0] SRCB_ONE = 2'd1;
    localparam logic [1:0] SRCB_IMM = 2'd2;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait watchdog used when MC_TIMEOUT_EN is defined: counts consecutive
// waiting cycles and flags the MAX_WAIT-th one so the controller can give up.
module mc_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic wait_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // The controller leaves the wait state on expiry, so the count never passes MAX_WAIT-1.
    assign count_d   = (clear_i || !wait_i) ? '0 : count_q + CNT_W'(1);
    assign expired_o = wait_i && (count_q == CNT_W'(MAX_WAIT - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB plus HALT and FAULT).
// Define MC_TIMEOUT_EN to bound FETCH/MEM waits to MAX_WAIT cycles.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int OPC_W    = 4,
    parameter int FUNC_W   = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [FUNC_W-1:0] funct,
    input  logic              zero,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic              ir_write,
    output logic              pc_write,
    output logic              reg_write,
    output logic              mem_to_reg,
    output logic              alu_src_a,
    output logic [1:0]        pc_src,
    output logic [1:0]        alu_src_b,
    output logic [3:0]        alu_op,
    output logic [2:0]        state,
    output logic              busy,
    output logic              fault
);

    if (FUNC_W < 4 || MAX_WAIT < 1) begin : g_param_check
        $error("multicycle_ctrl: FUNC_W must be >= 4 and MAX_WAIT >= 1");
    end

    localparam logic [OPC_W-1:0] OP_R    = OPC_W'(OPC_RTYPE);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(OPC_ADDI);
    localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(OPC_LW);
    localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(OPC_SW);
    localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(OPC_BEQ);
    localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(OPC_JMP);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(OPC_HALT);

    function automatic logic is_legal(input logic [OPC_W-1:0] op);
        return op inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JMP, OP_HALT};
    endfunction

    state_e           state_q, state_d;
    logic [OPC_W-1:0] opcode_q, opcode_d;
    logic             ack;
    logic             timeout;

    // A completion that coincides with reset must not strobe IR/PC writes.
    assign ack      = mem_ack && !rst;
    assign opcode_d = (state_q == ST_DECODE) ? opcode : opcode_q;

`ifdef MC_TIMEOUT_EN
    logic waiting;
    assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEM);

    mc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .wait_i    (waiting),
        .clear_i   (state_d != state_q),
        .expired_o (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        pc_src     = PC_SRC_PLUS1;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        case (state_q)
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_ONE;
                if (ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DECODE: state_d = is_legal(opcode) ? ST_EXEC : ST_FAULT;
            ST_EXEC: begin
                case (opcode_q)
                    OP_R: begin
                        alu_op    = funct[3:0];
                        alu_src_a = 1'b1;
                        state_d   = ST_WB;
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRCB_IMM;
                        state_d   = (opcode_q == OP_ADDI) ? ST_WB : ST_MEM;
                    end
                    OP_BEQ: begin
                        alu_op    = ALU_SUB;
                        alu_src_a = 1'b1;
                        pc_write  = zero;
                        pc_src    = PC_SRC_BRANCH;
                        state_d   = ST_FETCH;
                    end
                    OP_JMP: begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_JUMP;
                        state_d  = ST_FETCH;
                    end
                    OP_HALT: state_d = ST_HALT;
                    default: state_d = ST_FAULT;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (opcode_q == OP_SW);
                if (ack)          state_d = (opcode_q == OP_SW) ? ST_FETCH : ST_WB;
                else if (timeout) state_d = ST_FAULT;
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (opcode_q == OP_LW);
                state_d    = ST_FETCH;
            end
            ST_HALT, ST_FAULT: ;
            default: state_d = ST_FAULT;
        endcase
    end

    assign state = state_q;
    assign busy  = (state_q != ST_HALT) && (state_q != ST_FAULT);
    assign fault = (state_q == ST_FAULT);

endmodule
